sw_debounce: RTL and testbench

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce_if.sv | 23 ++
 rtl/sw_debounce.sv | 66 ++++++
 tb/tb_sw_debounce.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sw_debounce_if.sv
// rtl/sw_debounce_if.sv - switch input and debounced output bundle between board-facing logic and the debouncer
interface sw_debounce_if #(
   parameter int NUM_SW = 7
);
   logic [NUM_SW-1:0] sw;
   logic [NUM_SW-1:0] sw_db;
   logic [NUM_SW-1:0] sw_edge;
   logic              any_edge;

   modport master (
      output sw,
      input  sw_db,
      input  sw_edge,
      input  any_edge
   );

   modport slave (
      input  sw,
      output sw_db,
      output sw_edge,
      output any_edge
   );
endinterface

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - per-channel two-flop synchronizer, stability counter and registered change pulses
module sw_debounce #(
   parameter int NUM_SW        = 7,
   parameter int STABLE_CYCLES = 4
) (
   input  logic         clk,
   input  logic         reset,
   sw_debounce_if.slave bus
);
   localparam int              CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [NUM_SW-1:0] sw_meta_q,  sw_meta_d;
   logic [NUM_SW-1:0] sw_sync_q,  sw_sync_d;
   logic [NUM_SW-1:0] sw_db_q,    sw_db_d;
   logic [NUM_SW-1:0] sw_edge_q,  sw_edge_d;
   logic              any_edge_q, any_edge_d;
   logic [CNT_W-1:0]  cnt_q [NUM_SW];
   logic [CNT_W-1:0]  cnt_d [NUM_SW];

   // Any matching cycle zeroes the counter, so a bounce always restarts the run.
   always_comb begin
      sw_meta_d = bus.sw;
      sw_sync_d = sw_meta_q;
      sw_db_d   = sw_db_q;
      sw_edge_d = '0;
      for (int i = 0; i < NUM_SW; i++) begin
         cnt_d[i] = '0;
         if (sw_sync_q[i] != sw_db_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               sw_db_d[i]   = sw_sync_q[i];
               sw_edge_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
      any_edge_d = |sw_edge_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sw_meta_q  <= '0;
         sw_sync_q  <= '0;
         sw_db_q    <= '0;
         sw_edge_q  <= '0;
         any_edge_q <= 1'b0;
         for (int i = 0; i < NUM_SW; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sw_meta_q  <= sw_meta_d;
         sw_sync_q  <= sw_sync_d;
         sw_db_q    <= sw_db_d;
         sw_edge_q  <= sw_edge_d;
         any_edge_q <= any_edge_d;
         for (int i = 0; i < NUM_SW; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign bus.sw_db    = sw_db_q;
   assign bus.sw_edge  = sw_edge_q;
   assign bus.any_edge = any_edge_q;
endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - directed and randomized checks of sw_debounce against a sliding-window reference
module tb_sw_debounce;
   localparam int NSW  = 7;
   localparam int ST   = 4;
   localparam int MAXE = 4096;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sw_debounce_if #(.NUM_SW(NSW)) bus ();

   sw_debounce #(.NUM_SW(NSW), .STABLE_CYCLES(ST)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference: a level is accepted when the last ST synchronized samples all
   // disagree with it and none of those samples predate the previous flip/reset.
   logic [NSW-1:0] m_meta, m_sync, m_db, m_edge;
   logic           m_any;
   logic [NSW-1:0] hist [MAXE];
   int             last_flip [NSW];
   int             n = 0;
   int             pulses5;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic [NSW-1:0] s, input logic r);
      logic run_ok;
      if (n >= MAXE) begin
         $display("FAIL hist_overflow observed=%0d expected<%0d", n, MAXE);
         $fatal(1);
      end
      if (r) begin
         m_meta = '0;
         m_sync = '0;
         m_db   = '0;
         m_edge = '0;
         for (int i = 0; i < NSW; i++) last_flip[i] = n;
      end else begin
         hist[n] = m_sync;
         m_edge  = '0;
         for (int i = 0; i < NSW; i++) begin
            if (n - last_flip[i] >= ST) begin
               run_ok = 1'b1;
               for (int k = 0; k < ST; k++) begin
                  if (hist[n-k][i] == m_db[i]) run_ok = 1'b0;
               end
               if (run_ok) begin
                  m_db[i]      = ~m_db[i];
                  m_edge[i]    = 1'b1;
                  last_flip[i] = n;
               end
            end
         end
         m_sync = m_meta;
         m_meta = s;
      end
      m_any = |m_edge;
      n++;
   endtask

   task automatic step(input logic [NSW-1:0] s, input logic r);
      @(negedge clk);
      bus.sw = s;
      reset  = r;
      @(posedge clk);
      model_edge(s, r);
      #1;
      chk("model_db",   32'(bus.sw_db),    32'(m_db));
      chk("model_edge", 32'(bus.sw_edge),  32'(m_edge));
      chk("model_any",  32'(bus.any_edge), 32'(m_any));
      if (bus.sw_edge[5]) pulses5++;
   endtask

   task automatic dstep(input logic [NSW-1:0] s, input logic r,
                        input logic [NSW-1:0] edb, input logic [NSW-1:0] eedge);
      step(s, r);
      chk("dir_db",   32'(bus.sw_db),    32'(edb));
      chk("dir_edge", 32'(bus.sw_edge),  32'(eedge));
      chk("dir_any",  32'(bus.any_edge), 32'(|eedge));
   endtask

   task automatic hold(input logic [NSW-1:0] s, input int cycles);
      for (int c = 0; c < cycles; c++) step(s, 1'b0);
   endtask

   logic [NSW-1:0] cur;

   initial begin
      bus.sw  = '0;
      reset   = 1'b1;
      pulses5 = 0;
      for (int i = 0; i < NSW; i++) last_flip[i] = 0;
      m_meta = '0; m_sync = '0; m_db = '0; m_edge = '0; m_any = 1'b0;

      for (int c = 0; c < 3; c++) dstep(7'h00, 1'b1, 7'h00, 7'h00);
      for (int c = 0; c < 4; c++) dstep(7'h00, 1'b0, 7'h00, 7'h00);

      // single channel rise: new level visible on the sixth edge
      for (int c = 0; c < 5; c++) dstep(7'h01, 1'b0, 7'h00, 7'h00);
      dstep(7'h01, 1'b0, 7'h01, 7'h01);
      for (int c = 0; c < 4; c++) dstep(7'h01, 1'b0, 7'h01, 7'h00);

      // three-cycle glitch on sw[3] is rejected
      for (int c = 0; c < 3; c++) dstep(7'h09, 1'b0, 7'h01, 7'h00);
      for (int c = 0; c < 10; c++) dstep(7'h01, 1'b0, 7'h01, 7'h00);

      // bounce on sw[5]: 1,1,0 then held 1; only the last rise counts
      pulses5 = 0;
      dstep(7'h21, 1'b0, 7'h01, 7'h00);
      dstep(7'h21, 1'b0, 7'h01, 7'h00);
      dstep(7'h01, 1'b0, 7'h01, 7'h00);
      for (int c = 0; c < 5; c++) dstep(7'h21, 1'b0, 7'h01, 7'h00);
      dstep(7'h21, 1'b0, 7'h21, 7'h20);
      for (int c = 0; c < 6; c++) dstep(7'h21, 1'b0, 7'h21, 7'h00);
      chk("bounce_pulse_count", 32'(pulses5), 32'd1);

      // multi-channel simultaneous change
      hold(7'h00, 10);
      for (int c = 0; c < 5; c++) dstep(7'h55, 1'b0, 7'h00, 7'h00);
      dstep(7'h55, 1'b0, 7'h55, 7'h55);
      dstep(7'h55, 1'b0, 7'h55, 7'h00);
      hold(7'h55, 4);

      // reset mid-count discards progress, then full re-acceptance from zero
      for (int c = 0; c < 4; c++) dstep(7'h7F, 1'b0, 7'h55, 7'h00);
      dstep(7'h7F, 1'b1, 7'h00, 7'h00);
      for (int c = 0; c < 5; c++) dstep(7'h7F, 1'b0, 7'h00, 7'h00);
      dstep(7'h7F, 1'b0, 7'h7F, 7'h7F);
      dstep(7'h7F, 1'b0, 7'h7F, 7'h00);
      hold(7'h7F, 4);

      // all channels fall, then a long idle with no repeated pulses
      for (int c = 0; c < 5; c++) dstep(7'h00, 1'b0, 7'h7F, 7'h00);
      dstep(7'h00, 1'b0, 7'h00, 7'h7F);
      for (int c = 0; c < 110; c++) dstep(7'h00, 1'b0, 7'h00, 7'h00);

      // immediate re-toggle after acceptance needs a fresh full run
      for (int c = 0; c < 5; c++) dstep(7'h02, 1'b0, 7'h00, 7'h00);
      dstep(7'h00, 1'b0, 7'h02, 7'h02);
      dstep(7'h00, 1'b0, 7'h02, 7'h00);
      for (int c = 0; c < 3; c++) dstep(7'h00, 1'b0, 7'h02, 7'h00);
      dstep(7'h00, 1'b0, 7'h00, 7'h02);

      // randomized bouncing with occasional resets
      cur = '0;
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < NSW; i++) begin
            if ($urandom_range(0, 4) == 0) cur[i] = ~cur[i];
         end
         step(cur, ($urandom_range(0, 249) == 0));
      end
      hold(cur, 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
